vector_store_unit: RTL and testbench
====================================

Name: vector_store_unit

Overview:
- Drains one full vector register read from the vector register file into data memory, one element per memory write.
- Sits between the EX/MEM vector datapath and the data-memory write port.
- Stalls the pipeline until all lanes are written.
- Complements the register-file vector write path: that path assembles whole vectors, while this block serialises them back out with a valid/ready handshake.

Parameters:
- WIDTH, 24, element and memory address width in bits.
- VECTOR_WIDTH, 8, lanes per vector register.
- LANE_BITS, 3, lane counter width (log2 of VECTOR_WIDTH).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to store a vector; sampled only in IDLE.
- vec_in  in  [VECTOR_WIDTH-1:0][WIDTH-1:0]  vector read-port value in register-file order: architectural lane e is at vec_in[VECTOR_WIDTH-1-e].
- base_addr  in  WIDTH  memory address of lane 0.
- stride  in  WIDTH  byte/word address increment between consecutive lanes.
- mem_ready  in  1  memory accepts the current write this cycle.
- mem_we  out  1  write request valid.
- mem_addr  out  WIDTH  write address.
- mem_wdata  out  WIDTH  write data.
- busy  out  1  high in any state other than IDLE; drives the pipeline stall.
- done  out  1  one-cycle pulse when the last lane has been accepted.

Behaviour:
- Reset (asynchronous, effective immediately):
  - state=IDLE, lane=0, all captured registers=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0.
- Reset mid-transfer aborts the transfer; no further writes are issued and there is no done pulse.
- States: IDLE, SEND, DONE.
- IDLE:
  - On start=1, capture vec_in, base_addr and stride.
  - Set lane=0 and addr_q=base_addr, then go to SEND next cycle.
  - start=0 keeps the block in IDLE.
- SEND:
  - mem_we=1, mem_addr=addr_q, mem_wdata=captured lane `lane` (taken from captured vec_in[VECTOR_WIDTH-1-lane]).
  - Outputs are held stable while mem_ready=0 (valid must not drop or change until accepted).
- Handshake: a write completes in any cycle where mem_we and mem_ready are both 1.
  - On completion with lane<VECTOR_WIDTH-1: lane+=1, addr_q+=stride.
  - On completion with lane==VECTOR_WIDTH-1: go to DONE.
- DONE: done=1 and mem_we=0 for exactly one cycle, then IDLE; busy is still 1 in DONE.
- start while busy=1 is ignored and not queued.
- Changes to vec_in, base_addr or stride after capture have no effect.
- Address arithmetic is modulo 2^WIDTH; wrap past all-ones continues from 0 with no error.
- stride=0 is legal: all lanes go to base_addr and the last write wins in memory.
- Latency with mem_ready tied high: start sampled in cycle 0, writes in cycles 1..8, done in cycle 9, IDLE in cycle 10, and a new start is accepted in cycle 10.
- Each cycle of mem_ready=0 in SEND adds one cycle.
- mem_addr and mem_wdata hold their last driven value when mem_we=0. Verification checks them only while mem_we=1.

Optional Feature:
- VSTORE_MASK_EN: adds input lane_mask [VECTOR_WIDTH-1:0] (bit e = architectural lane e), captured together with start.
  - In SEND, a lane whose mask bit is 0 takes exactly one cycle with mem_we=0; mem_ready is ignored for that lane, lane and addr_q still advance by one and stride.
  - Timing of the following lanes is therefore unchanged versus all-ones.
  - An all-zero mask still walks all lanes and pulses done.
- Without the macro: no lane_mask port, and every lane is written.

Decomposition:
- Shared package vec_pkg holds:
  - constants WIDTH=24, VECTOR_WIDTH=8, LANE_BITS=3;
  - typedef elem_t (logic [WIDTH-1:0]);
  - typedef vector_t (logic [VECTOR_WIDTH-1:0][WIDTH-1:0]);
  - enum vst_state_t {IDLE, SEND, DONE}.
- The register file and later vector-load blocks reuse these types.
- No sub-module: the lane select and address accumulator are small enough to stay inline.

Test Plan:
- Basic store, mem_ready=1: vec_in with lane e=24'h000010+e, base=24'h000100, stride=1, start pulse -> 8 writes at addrs 0x100..0x107 with data 0x10..0x17 in cycles 1..8; done in cycle 9; busy high cycles 1..9.
- Backpressure: same stimulus, mem_ready=0 on cycles 2,3 and 6 -> addr 0x101/data 0x11 held stable across the stalls; done in cycle 12; each address written once.
- Stride and wrap: base=24'hFFFFFE, stride=1 -> addrs FFFFFE, FFFFFF, 000000..000005.
- stride=4, base=0 -> addrs 0,4,...,28.
- Ignored start and input changes: assert start again in cycle 3 and change vec_in/base_addr in cycle 2 -> the original 8 writes are unchanged and no second transfer occurs.
- Reset mid-op: assert rst asynchronously during lane 4 -> mem_we=0 immediately, no done; after rst is released, start with base=0x200 -> a clean fresh 8-lane transfer.
- Mask (VSTORE_MASK_EN): lane_mask=8'b1010_0101 -> writes only lanes 0,2,5,7 at base+e; done still in cycle 9.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared vector types and sizing for the vector register file, store and load blocks.
package vec_pkg;

   localparam int WIDTH        = 24;
   localparam int VECTOR_WIDTH = 8;
   localparam int LANE_BITS    = 3;

   typedef logic [WIDTH-1:0]                    elem_t;
   typedef logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  vector_t;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE
   } vst_state_t;

endpackage

// File: rtl/vector_store_unit.sv
// Serialises one captured vector register into data memory, one lane per accepted write.
// Optional VSTORE_MASK_EN adds a per-lane write mask captured with start.
module vector_store_unit
   import vec_pkg::*;
(
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  vec_in,
   input  logic [WIDTH-1:0]                    base_addr,
   input  logic [WIDTH-1:0]                    stride,
`ifdef VSTORE_MASK_EN
   input  logic [VECTOR_WIDTH-1:0]             lane_mask,
`endif
   input  logic                                mem_ready,
   output logic                                mem_we,
   output logic [WIDTH-1:0]                    mem_addr,
   output logic [WIDTH-1:0]                    mem_wdata,
   output logic                                busy,
   output logic                                done
);

   localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(VECTOR_WIDTH - 1);

   vst_state_t           state_reg, state_next;
   logic [LANE_BITS-1:0] lane_reg, lane_next;
   elem_t                addr_reg, addr_next;
   elem_t                stride_reg, stride_next;
   vector_t              vec_reg, vec_next;
   elem_t                lane_data [VECTOR_WIDTH];
   logic                 lane_en;

   // Register-file order is reversed: architectural lane e lives at index VECTOR_WIDTH-1-e.
   generate
      for (genvar gi = 0; gi < VECTOR_WIDTH; gi++) begin : g_lane
         assign lane_data[gi] = vec_reg[VECTOR_WIDTH-1-gi];
      end
   endgenerate

`ifdef VSTORE_MASK_EN
   logic [VECTOR_WIDTH-1:0] mask_reg, mask_next;
   assign lane_en = mask_reg[lane_reg];
`else
   assign lane_en = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         lane_reg   <= '0;
         addr_reg   <= '0;
         stride_reg <= '0;
         vec_reg    <= '0;
`ifdef VSTORE_MASK_EN
         mask_reg   <= '0;
`endif
      end else begin
         state_reg  <= state_next;
         lane_reg   <= lane_next;
         addr_reg   <= addr_next;
         stride_reg <= stride_next;
         vec_reg    <= vec_next;
`ifdef VSTORE_MASK_EN
         mask_reg   <= mask_next;
`endif
      end
   end

   always_comb begin
      state_next  = state_reg;
      lane_next   = lane_reg;
      addr_next   = addr_reg;
      stride_next = stride_reg;
      vec_next    = vec_reg;
`ifdef VSTORE_MASK_EN
      mask_next   = mask_reg;
`endif
      mem_we      = 1'b0;
      mem_addr    = addr_reg;
      mem_wdata   = lane_data[lane_reg];
      busy        = (state_reg != IDLE);
      done        = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               vec_next    = vec_in;
               stride_next = stride;
               addr_next   = base_addr;
               lane_next   = '0;
`ifdef VSTORE_MASK_EN
               mask_next   = lane_mask;
`endif
               state_next  = SEND;
            end
         end
         SEND: begin
            mem_we = lane_en;
            // A masked-off lane consumes its slot without waiting on the memory.
            if (!lane_en || mem_ready) begin
               if (lane_reg == LAST_LANE) begin
                  state_next = DONE;
               end else begin
                  lane_next = lane_reg + LANE_BITS'(1);
                  addr_next = addr_reg + stride_reg;
               end
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_vector_store_unit.sv
// Scoreboard bench for vector_store_unit: stimulus pushes expected writes/done, a monitor pops and compares.
module tb_vector_store_unit;
   import vec_pkg::*;

   logic    clk = 1'b0;
   logic    rst;
   logic    start;
   vector_t vec_in;
   elem_t   base_addr;
   elem_t   stride;
   logic    mem_ready;
   logic    mem_we;
   elem_t   mem_addr;
   elem_t   mem_wdata;
   logic    busy;
   logic    done;
`ifdef VSTORE_MASK_EN
   logic [VECTOR_WIDTH-1:0] lane_mask;
`endif

   always #5 clk = ~clk;

   vector_store_unit dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .vec_in    (vec_in),
      .base_addr (base_addr),
      .stride    (stride),
`ifdef VSTORE_MASK_EN
      .lane_mask (lane_mask),
`endif
      .mem_ready (mem_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done)
   );

   typedef struct {
      elem_t addr;
      elem_t data;
      int    cyc;
   } wr_t;

   wr_t         wq[$];
   int          dq[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          t0       = 0;
   logic [63:0] stall_mask = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Cycle counter and memory backpressure, relative to the cycle start was sampled in.
   int r_drv;
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      r_drv = cyc - t0;
      mem_ready = (r_drv >= 0 && r_drv < 64) ? ~stall_mask[r_drv] : 1'b1;
   end

   // Monitor
   int    rel;
   logic  prev_stall = 1'b0;
   elem_t prev_addr, prev_data;
   wr_t   e;
   int    d;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         rel = cyc - t0;
         if (prev_stall) begin
            chk("stall_we_held", {31'd0, mem_we}, 32'd1);
            if (mem_we) begin
               chk("stall_addr_held", mem_addr, prev_addr);
               chk("stall_data_held", mem_wdata, prev_data);
            end
         end
         if (mem_we && mem_ready) begin
            if (wq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: addr %0h data %0h at rel cycle %0d, none expected", mem_addr, mem_wdata, rel);
            end else begin
               e = wq.pop_front();
               chk("wr_addr", mem_addr, e.addr);
               chk("wr_data", mem_wdata, e.data);
               chk("wr_cycle", rel, e.cyc);
               $display("write addr=%06h data=%06h cycle=%0d", mem_addr, mem_wdata, rel);
            end
         end
         prev_stall = mem_we && !mem_ready;
         prev_addr  = mem_addr;
         prev_data  = mem_wdata;
         if (done) begin
            chk("done_we_low", {31'd0, mem_we}, 32'd0);
            if (dq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got done at rel cycle %0d, none expected", rel);
            end else begin
               d = dq.pop_front();
               chk("done_cycle", rel, d);
               $display("done cycle=%0d", rel);
            end
         end
      end
   end

   function automatic vector_t mk_vec(input elem_t d0);
      vector_t v;
      for (int i = 0; i < VECTOR_WIDTH; i++) v[VECTOR_WIDTH-1-i] = d0 + elem_t'(i);
      return v;
   endfunction

   task automatic run_store(input elem_t base, input elem_t st, input elem_t d0,
                            input logic [VECTOR_WIDTH-1:0] mask, input logic [63:0] stl,
                            input bit disturb);
      int  c;
      int  exp_done;
      wr_t w;
      c = 1;
      for (int i = 0; i < VECTOR_WIDTH; i++) begin
         if (!mask[i]) begin
            c++;
         end else begin
            while (stl[c]) c++;
            w.addr = base + elem_t'(i) * st;
            w.data = d0 + elem_t'(i);
            w.cyc  = c;
            wq.push_back(w);
            c++;
         end
      end
      exp_done = c;
      dq.push_back(exp_done);

      @(negedge clk);
      vec_in     = mk_vec(d0);
      base_addr  = base;
      stride     = st;
`ifdef VSTORE_MASK_EN
      lane_mask  = mask;
`endif
      stall_mask = stl;
      t0         = cyc;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      if (disturb) begin
         @(negedge clk);
         vec_in    = mk_vec(24'h00ABC0);
         base_addr = 24'h000F00;
         stride    = 24'h000003;
         @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      for (int i = 0; i < 60 && dq.size() != 0; i++) begin
         @(negedge clk);
         if (dq.size() != 0 && (cyc - t0) <= exp_done) chk("busy_during", {31'd0, busy}, 32'd1);
      end
      if (dq.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: got no done, expected done at cycle %0d", exp_done);
         dq.delete();
      end
      chk("writes_drained", wq.size(), 32'd0);
      wq.delete();
      repeat (2) @(negedge clk);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      repeat (4) @(negedge clk);
      stall_mask = '0;
   endtask

   task automatic run_reset_mid;
      wr_t w;
      for (int i = 0; i < 5; i++) begin
         w.addr = 24'h000300 + elem_t'(i);
         w.data = 24'h000040 + elem_t'(i);
         w.cyc  = i + 1;
         wq.push_back(w);
      end
      @(negedge clk);
      vec_in    = mk_vec(24'h000040);
      base_addr = 24'h000300;
      stride    = 24'h000001;
`ifdef VSTORE_MASK_EN
      lane_mask = '1;
`endif
      t0    = cyc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_done", {31'd0, done}, 32'd0);
      chk("rst_mid_lanes_seen", wq.size(), 32'd0);
      wq.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      vec_in    = '0;
      base_addr = '0;
      stride    = '0;
      mem_ready = 1'b1;
`ifdef VSTORE_MASK_EN
      lane_mask = '1;
`endif
      #1;
      chk("reset_we", {31'd0, mem_we}, 32'd0);
      chk("reset_addr", mem_addr, 32'd0);
      chk("reset_wdata", mem_wdata, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_store(24'h000100, 24'h000001, 24'h000010, '1, 64'h0, 1'b0);   // basic
      run_store(24'h000100, 24'h000001, 24'h000010, '1, 64'h4C, 1'b0);  // stalls in cycles 2,3,6
      run_store(24'hFFFFFE, 24'h000001, 24'h000020, '1, 64'h0, 1'b0);   // address wrap
      run_store(24'h000000, 24'h000004, 24'h000030, '1, 64'h0, 1'b0);   // stride 4
      run_store(24'h000100, 24'h000001, 24'h000010, '1, 64'h0, 1'b1);   // ignored start/input changes
      run_reset_mid();
      run_store(24'h000200, 24'h000001, 24'h000050, '1, 64'h0, 1'b0);   // clean transfer after reset
`ifdef VSTORE_MASK_EN
      run_store(24'h000400, 24'h000001, 24'h000010, 8'b1010_0101, 64'h0, 1'b0);
      run_store(24'h000500, 24'h000001, 24'h000060, 8'b0000_0000, 64'h0, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
